// File: rtl/swarm.sv
`default_nettype none
// ============================================================================
//  Module      : swarm (package)
//  Description : Tile-wide constants and shared types for the L2 request
//                arbiter: port count, address width, arbiter FSM encoding,
//                request payload struct and small arithmetic helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package swarm;

  localparam int L2_PORTS            = 4;
  localparam int ADDR_BITS           = 34;
  localparam int L2_ARB_ID_W         = 8;
  localparam int L2_ARB_LOG_N_MSHR   = 4;
  localparam int L2_ARB_MAX_INFLIGHT = 4;

  typedef enum logic [1:0] {
    L2_ARB_RUN   = 2'd0,
    L2_ARB_DRAIN = 2'd1,
    L2_ARB_IDLE  = 2'd2
  } l2_arb_state_t;

  // Request payload at the tile's default widths.
  typedef struct packed {
    logic [ADDR_BITS-1:0]   addr;
    logic [L2_ARB_ID_W-1:0] id;
    logic                   write;
  } l2_req_t;

  // Single-step modulo wrap: valid for v < 2*n.
  function automatic int unsigned l2_arb_wrap(input int unsigned v, input int unsigned n);
    return (v >= n) ? (v - n) : v;
  endfunction

  // 32-bit increment that sticks at all-ones.
  function automatic logic [31:0] l2_arb_sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : (v + 32'd1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_picker.sv
`default_nettype none
// ============================================================================
//  Module      : rr_picker
//  Description : Combinational round-robin search. Starting at ptr_i and
//                wrapping modulo N, returns the first set bit of eligible_i
//                as a one-hot grant and as an encoded index.
//  Ports       : eligible_i  [N]   candidate mask
//                ptr_i       [IW]  search start (must be < N)
//                grant_o     [N]   one-hot winner (zero if none)
//                idx_o       [IW]  encoded winner (zero if none)
//                found_o     [1]   any candidate eligible
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_picker
  import swarm::*;
#(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  eligible_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] idx_o,
  output logic          found_o
);

  logic [IW-1:0] w_pos;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    found_o = 1'b0;
    w_pos   = '0;
    for (int k = 0; k < N; k++) begin
      w_pos = IW'(l2_arb_wrap(int'(ptr_i) + k, N));
      if (!found_o && eligible_i[w_pos]) begin
        grant_o[w_pos] = 1'b1;
        idx_o          = w_pos;
        found_o        = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/l2_req_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : l2_req_arbiter
//  Description : Round-robin arbiter sharing one L2 bank request pipeline
//                among N_PORTS requesters. One registered output stage,
//                a global MSHR credit pool, a per-port in-flight limit and
//                a drain sequence (RUN -> DRAIN -> IDLE) that blocks grants
//                until every outstanding request has retired.
//  Ports       : clk, rst                     clock, sync active-high reset
//                in_valid/in_ready [N]        per-port handshake
//                in_addr/in_id/in_write       per-port payload, packed
//                out_valid/out_ready          registered output handshake
//                out_addr/out_id/out_write    granted payload
//                out_port                     granted port index
//                resp_valid/resp_port         retirement, returns a credit
//                drain_req/drain_done         drain level request / status
//                credit_err                   sticky over-retirement flag
//                stat_sel/stat_rdata          statistics read (optional)
//  Options     : L2_ARB_STATS_EN adds per-port grant/conflict counters,
//                a credit-stall counter and the stat_sel/stat_rdata port.
//  Revision    : 1.0 - initial release
// ============================================================================
module l2_req_arbiter
  import swarm::*;
#(
  parameter int N_PORTS      = swarm::L2_PORTS,
  parameter int ADDR_W       = swarm::ADDR_BITS,
  parameter int ID_W         = swarm::L2_ARB_ID_W,
  parameter int LOG_N_MSHR   = swarm::L2_ARB_LOG_N_MSHR,
  parameter int MAX_INFLIGHT = swarm::L2_ARB_MAX_INFLIGHT,
  localparam int c_PORT_W    = (N_PORTS > 1) ? $clog2(N_PORTS) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_PORTS-1:0]        in_valid,
  output logic [N_PORTS-1:0]        in_ready,
  input  logic [N_PORTS*ADDR_W-1:0] in_addr,
  input  logic [N_PORTS*ID_W-1:0]   in_id,
  input  logic [N_PORTS-1:0]        in_write,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [ADDR_W-1:0]         out_addr,
  output logic [ID_W-1:0]           out_id,
  output logic                      out_write,
  output logic [c_PORT_W-1:0]       out_port,
  input  logic                      resp_valid,
  input  logic [c_PORT_W-1:0]       resp_port,
  input  logic                      drain_req,
  output logic                      drain_done,
`ifdef L2_ARB_STATS_EN
  input  logic [c_PORT_W:0]         stat_sel,
  output logic [31:0]               stat_rdata,
`endif
  output logic                      credit_err
);

  localparam int            c_CRED_W = LOG_N_MSHR + 1;
  localparam int            c_CNT_W  = $clog2(MAX_INFLIGHT + 1);
  localparam logic [c_CRED_W-1:0] c_FULL   = c_CRED_W'(1) << LOG_N_MSHR;
  localparam logic [c_CNT_W-1:0]  c_MAX_IF = c_CNT_W'(MAX_INFLIGHT);

  // ---------------------------------------------------------------- state
  logic [c_CRED_W-1:0] credits_q, credits_d;
  logic [c_CNT_W-1:0]  cnt_q [N_PORTS];
  logic [c_CNT_W-1:0]  cnt_d [N_PORTS];
  logic [c_PORT_W-1:0] ptr_q, ptr_d;
  l2_arb_state_t       state_q;
  logic                drain_done_q;
  logic                credit_err_q;

  logic                out_valid_q, out_valid_d;
  logic [ADDR_W-1:0]   out_addr_q;
  logic [ID_W-1:0]     out_id_q;
  logic                out_write_q;
  logic [c_PORT_W-1:0] out_port_q;

  // ---------------------------------------------------------------- wires
  logic [N_PORTS-1:0]  w_eligible;
  logic [N_PORTS-1:0]  w_pick_grant;
  logic [c_PORT_W-1:0] w_pick_idx;
  logic                w_pick_found;
  logic                w_load;
  logic                w_grant;
  logic                w_resp_hit;
  logic                w_resp_ok;
  logic                w_resp_bad;
  logic                w_quiesce_d;

  for (genvar i = 0; i < N_PORTS; i++) begin : g_elig
    assign w_eligible[i] = in_valid[i] && (cnt_q[i] < c_MAX_IF);
  end

  rr_picker #(
    .N  (N_PORTS),
    .IW (c_PORT_W)
  ) u_picker (
    .eligible_i (w_eligible),
    .ptr_i      (ptr_q),
    .grant_o    (w_pick_grant),
    .idx_o      (w_pick_idx),
    .found_o    (w_pick_found)
  );

  // The output stage can take a new request when it is empty or being
  // popped this cycle; the credit pool and the FSM gate it further.
  assign w_load   = (!out_valid_q || out_ready) && (credits_q != '0) &&
                    (state_q == L2_ARB_RUN);
  assign w_grant  = w_load && w_pick_found;
  assign in_ready = w_load ? w_pick_grant : '0;

  // A retirement only counts when the named port has something in flight;
  // otherwise it is flagged and ignored so the accounting stays sane.
  always_comb begin
    w_resp_hit = 1'b0;
    for (int i = 0; i < N_PORTS; i++) begin
      if (resp_port == c_PORT_W'(i) && cnt_q[i] != '0) begin
        w_resp_hit = 1'b1;
      end
    end
  end

  assign w_resp_ok  = resp_valid && w_resp_hit;
  assign w_resp_bad = resp_valid && !w_resp_hit;

  always_comb begin
    credits_d = credits_q;
    if (w_grant && !w_resp_ok) begin
      credits_d = credits_q - c_CRED_W'(1);
    end else if (w_resp_ok && !w_grant && credits_q != c_FULL) begin
      credits_d = credits_q + c_CRED_W'(1);
    end
  end

  always_comb begin
    for (int i = 0; i < N_PORTS; i++) begin
      cnt_d[i] = cnt_q[i];
      if (w_grant && w_pick_idx == c_PORT_W'(i) &&
          !(w_resp_ok && resp_port == c_PORT_W'(i))) begin
        cnt_d[i] = cnt_q[i] + c_CNT_W'(1);
      end else if (w_resp_ok && resp_port == c_PORT_W'(i) &&
                   !(w_grant && w_pick_idx == c_PORT_W'(i))) begin
        cnt_d[i] = cnt_q[i] - c_CNT_W'(1);
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (w_grant) begin
      ptr_d = (w_pick_idx == c_PORT_W'(N_PORTS - 1)) ? '0
                                                     : (w_pick_idx + c_PORT_W'(1));
    end
  end

  assign out_valid_d = w_grant || (out_valid_q && !out_ready);
  // Drain completes on the edge where the last credit comes home and the
  // output stage is (or becomes) empty, so drain_done rises next cycle.
  assign w_quiesce_d = !out_valid_d && (credits_d == c_FULL);

  // ------------------------------------------------------ datapath regs
  always_ff @(posedge clk) begin
    if (rst) begin
      credits_q    <= c_FULL;
      ptr_q        <= '0;
      credit_err_q <= 1'b0;
      out_valid_q  <= 1'b0;
      out_addr_q   <= '0;
      out_id_q     <= '0;
      out_write_q  <= 1'b0;
      out_port_q   <= '0;
      for (int i = 0; i < N_PORTS; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      credits_q    <= credits_d;
      ptr_q        <= ptr_d;
      credit_err_q <= credit_err_q | w_resp_bad;
      out_valid_q  <= out_valid_d;
      for (int i = 0; i < N_PORTS; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      if (w_grant) begin
        out_addr_q  <= in_addr[int'(w_pick_idx)*ADDR_W +: ADDR_W];
        out_id_q    <= in_id[int'(w_pick_idx)*ID_W +: ID_W];
        out_write_q <= in_write[w_pick_idx];
        out_port_q  <= w_pick_idx;
      end
    end
  end

  // ------------------------------------------------------------ drain FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= L2_ARB_RUN;
      drain_done_q <= 1'b0;
    end else begin
      case (state_q)
        L2_ARB_RUN: begin
          if (drain_req) begin
            state_q <= L2_ARB_DRAIN;
          end
        end
        L2_ARB_DRAIN: begin
          if (!drain_req) begin
            state_q <= L2_ARB_RUN;
          end else if (w_quiesce_d) begin
            state_q      <= L2_ARB_IDLE;
            drain_done_q <= 1'b1;
          end
        end
        L2_ARB_IDLE: begin
          if (!drain_req) begin
            state_q      <= L2_ARB_RUN;
            drain_done_q <= 1'b0;
          end
        end
        default: begin
          state_q      <= L2_ARB_RUN;
          drain_done_q <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid  = out_valid_q;
  assign out_addr   = out_addr_q;
  assign out_id     = out_id_q;
  assign out_write  = out_write_q;
  assign out_port   = out_port_q;
  assign drain_done = drain_done_q;
  assign credit_err = credit_err_q;

`ifdef L2_ARB_STATS_EN
  // Read map: {0,i} = grants of port i, {1,i} = conflict cycles of port i;
  // select codes naming no port return the credit-stall counter.
  logic [31:0] st_grant_q [N_PORTS];
  logic [31:0] st_conf_q  [N_PORTS];
  logic [31:0] st_stall_q;
  logic [31:0] stat_rdata_q;
  logic [31:0] w_stat_mux;

  always_comb begin
    w_stat_mux = st_stall_q;
    for (int i = 0; i < N_PORTS; i++) begin
      if (stat_sel == {1'b0, c_PORT_W'(i)}) begin
        w_stat_mux = st_grant_q[i];
      end
      if (stat_sel == {1'b1, c_PORT_W'(i)}) begin
        w_stat_mux = st_conf_q[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_stall_q   <= '0;
      stat_rdata_q <= '0;
      for (int i = 0; i < N_PORTS; i++) begin
        st_grant_q[i] <= '0;
        st_conf_q[i]  <= '0;
      end
    end else begin
      stat_rdata_q <= w_stat_mux;
      if (credits_q == '0 && |in_valid) begin
        st_stall_q <= l2_arb_sat_inc(st_stall_q);
      end
      for (int i = 0; i < N_PORTS; i++) begin
        if (in_ready[i]) begin
          st_grant_q[i] <= l2_arb_sat_inc(st_grant_q[i]);
        end
        if (in_valid[i] && !in_ready[i]) begin
          st_conf_q[i] <= l2_arb_sat_inc(st_conf_q[i]);
        end
      end
    end
  end

  assign stat_rdata = stat_rdata_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_l2_req_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_l2_req_arbiter
//  Description : Directed self-checking bench for l2_req_arbiter. Expected
//                grants come from a behavioural model of the arbiter; each
//                expected request is queued when it is offered and compared
//                against out_* while the DUT holds it.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_l2_req_arbiter;

  localparam int N    = 4;
  localparam int AW   = 34;
  localparam int IW   = 8;
  localparam int MAXI = 4;
  localparam int FULL = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    in_valid;
  logic [N-1:0]    in_ready;
  logic [N*AW-1:0] in_addr;
  logic [N*IW-1:0] in_id;
  logic [N-1:0]    in_write;
  logic            out_valid;
  logic            out_ready;
  logic [AW-1:0]   out_addr;
  logic [IW-1:0]   out_id;
  logic            out_write;
  logic [1:0]      out_port;
  logic            resp_valid;
  logic [1:0]      resp_port;
  logic            drain_req;
  logic            drain_done;
  logic            credit_err;
`ifdef L2_ARB_STATS_EN
  logic [2:0]      stat_sel;
  logic [31:0]     stat_rdata;
`endif

  always #5 clk = ~clk;

  l2_req_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_addr    (in_addr),
    .in_id      (in_id),
    .in_write   (in_write),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_addr   (out_addr),
    .out_id     (out_id),
    .out_write  (out_write),
    .out_port   (out_port),
    .resp_valid (resp_valid),
    .resp_port  (resp_port),
    .drain_req  (drain_req),
    .drain_done (drain_done),
`ifdef L2_ARB_STATS_EN
    .stat_sel   (stat_sel),
    .stat_rdata (stat_rdata),
`endif
    .credit_err (credit_err)
  );

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [IW-1:0] id;
    logic          write;
    logic [1:0]    port;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  // Behavioural model
  int   m_ptr;
  int   m_cnt [N];
  int   m_cred;
  int   m_state;   // 0 run, 1 drain, 2 idle
  bit   m_ov, m_err, m_dd;
  int   seq [N];

  function automatic logic [AW-1:0] addr_of(input int p, input int s);
    return (AW'(p) << 30) | AW'(s * 37 + 5);
  endfunction

  function automatic logic [IW-1:0] id_of(input int p, input int s);
    return IW'(s * 16 + p + 1);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ptr = 0; m_cred = FULL; m_state = 0;
    m_ov = 0; m_err = 0; m_dd = 0;
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
    sb.delete();
  endtask

  // One clock: inputs already set at the negedge by the caller.
  task automatic cycle(output logic [N-1:0] obs);
    bit ld, g, rok, ov_old;
    int gi;
    logic [N-1:0] exp_rdy;
    exp_t e;
    for (int i = 0; i < N; i++) begin
      in_addr[i*AW +: AW] = addr_of(i, seq[i]);
      in_id[i*IW +: IW]   = id_of(i, seq[i]);
      in_write[i]         = ((seq[i] + i) % 2) == 1;
    end
    #1;
    ld = (!m_ov || out_ready) && m_cred > 0 && m_state == 0;
    g = 0; gi = 0; exp_rdy = '0;
    if (ld) begin
      for (int k = 0; k < N; k++) begin
        int p;
        p = (m_ptr + k) % N;
        if (!g && in_valid[p] && m_cnt[p] < MAXI) begin
          g = 1; gi = p;
        end
      end
    end
    if (g) exp_rdy[gi] = 1'b1;
    obs = in_ready;
    chk("in_ready", 64'(in_ready), 64'(exp_rdy));
    if (g) begin
      e.addr  = addr_of(gi, seq[gi]);
      e.id    = id_of(gi, seq[gi]);
      e.write = ((seq[gi] + gi) % 2) == 1;
      e.port  = 2'(gi);
      sb.push_back(e);
    end
    ov_old = m_ov;
    @(posedge clk);
    rok = resp_valid && m_cnt[resp_port] > 0;
    if (resp_valid && !rok) m_err = 1;
    if (g) begin m_cnt[gi]++; m_cred--; m_ptr = (gi + 1) % N; seq[gi]++; end
    if (rok) begin m_cnt[resp_port]--; m_cred++; end
    if (ov_old && out_ready && sb.size() > 0) void'(sb.pop_front());
    m_ov = g ? 1'b1 : (out_ready ? 1'b0 : m_ov);
    case (m_state)
      0: if (drain_req) m_state = 1;
      1: if (!drain_req) m_state = 0;
         else if (!m_ov && m_cred == FULL) m_state = 2;
      default: if (!drain_req) m_state = 0;
    endcase
    m_dd = (m_state == 2);
    #1;
    chk("out_valid", 64'(out_valid), 64'(m_ov));
    if (m_ov && sb.size() > 0) begin
      chk("out_addr",  64'(out_addr),  64'(sb[0].addr));
      chk("out_id",    64'(out_id),    64'(sb[0].id));
      chk("out_write", 64'(out_write), 64'(sb[0].write));
      chk("out_port",  64'(out_port),  64'(sb[0].port));
    end
    chk("drain_done", 64'(drain_done), 64'(m_dd));
    chk("credit_err", 64'(credit_err), 64'(m_err));
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1; in_valid = '0; out_ready = 1; resp_valid = 0; resp_port = '0; drain_req = 0;
    @(posedge clk); @(posedge clk); #1;
    model_reset();
    chk("rst_out_valid",  64'(out_valid),  64'd0);
    chk("rst_drain_done", 64'(drain_done), 64'd0);
    chk("rst_credit_err", 64'(credit_err), 64'd0);
    @(negedge clk);
    rst = 0;
  endtask

  initial begin
    logic [N-1:0] obs;
    int n;
    in_addr = '0; in_id = '0; in_write = '0;
`ifdef L2_ARB_STATS_EN
    stat_sel = '0;
`endif
    for (int i = 0; i < N; i++) seq[i] = 0;
    @(negedge clk);
    do_reset();

    // Round-robin order with retirements every cycle.
    in_valid = 4'hF; out_ready = 1;
    for (int k = 0; k < 5; k++) begin
      resp_valid = (k > 0);
      resp_port  = 2'((k + 3) % N);
      cycle(obs);
      chk("rr_order_port", 64'(out_port), 64'(k % N));
    end
    resp_valid = 0;

    // Per-port in-flight limit.
    do_reset();
    in_valid = 4'b0001; n = 0;
    for (int k = 0; k < 7; k++) begin cycle(obs); if (obs != '0) n++; end
    chk("port_limit_grants", 64'(n), 64'(MAXI));
    resp_valid = 1; resp_port = 2'd0; n = 0;
    cycle(obs); if (obs != '0) n++;
    resp_valid = 0;
    for (int k = 0; k < 4; k++) begin cycle(obs); if (obs != '0) n++; end
    chk("port_limit_regrant", 64'(n), 64'd1);

    // Global credit limit.
    do_reset();
    in_valid = 4'hF; n = 0;
    for (int k = 0; k < 22; k++) begin cycle(obs); if (obs != '0) n++; end
    chk("credit_limit_grants", 64'(n), 64'(FULL));
    resp_valid = 1; resp_port = 2'd1; n = 0;
    cycle(obs); if (obs != '0) n++;
    resp_valid = 0;
    for (int k = 0; k < 4; k++) begin cycle(obs); if (obs != '0) n++; end
    chk("credit_limit_regrant", 64'(n), 64'd1);

    // Backpressure: held request stays stable, no new grants.
    do_reset();
    in_valid = 4'b0001; out_ready = 0;
    cycle(obs);
    chk("bp_first_grant", 64'(obs), 64'b0001);
    in_valid = 4'b0010; n = 0;
    for (int k = 0; k < 10; k++) begin cycle(obs); if (obs != '0) n++; end
    chk("bp_no_grant", 64'(n), 64'd0);
    out_ready = 1;
    cycle(obs);
    chk("bp_pop_regrant", 64'(obs), 64'b0010);
    in_valid = '0;
    cycle(obs);

    // Drain with three requests in flight.
    do_reset();
    in_valid = 4'b0111;
    for (int k = 0; k < 3; k++) cycle(obs);
    in_valid = '0; drain_req = 1;
    cycle(obs);
    in_valid = 4'hF; n = 0;
    for (int k = 0; k < 3; k++) begin cycle(obs); if (obs != '0) n++; end
    for (int p = 0; p < 3; p++) begin
      resp_valid = 1; resp_port = 2'(p);
      chk("drain_done_before", 64'(drain_done), 64'd0);
      cycle(obs); if (obs != '0) n++;
    end
    resp_valid = 0;
    chk("drain_no_grants", 64'(n), 64'd0);
    chk("drain_done_rise", 64'(drain_done), 64'd1);
    cycle(obs);
    chk("drain_done_hold", 64'(drain_done), 64'd1);
    drain_req = 0;
    cycle(obs);
    chk("drain_exit_no_grant", 64'(obs), 64'd0);
    chk("drain_done_fall", 64'(drain_done), 64'd0);
    cycle(obs);
    chk("drain_resume_grant", 64'(obs), 64'b1000);
    in_valid = '0;
    cycle(obs);

    // Spurious retirement: sticky error, no credit returned.
    do_reset();
    resp_valid = 1; resp_port = 2'd2;
    cycle(obs);
    chk("cerr_set", 64'(credit_err), 64'd1);
    resp_valid = 0;
    for (int k = 0; k < 3; k++) cycle(obs);
    chk("cerr_sticky", 64'(credit_err), 64'd1);
    in_valid = 4'hF; n = 0;
    for (int k = 0; k < 20; k++) begin cycle(obs); if (obs != '0) n++; end
    chk("cerr_credits_unchanged", 64'(n), 64'(FULL));
    do_reset();
    chk("cerr_cleared", 64'(credit_err), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/l2_req_arbiter.md
Name: l2_req_arbiter

Overview:
- Shares one L2 cache bank's request pipeline among the tile's N_PORTS requesters (RO stages, RW read, RW write).
- Each cycle, picks one requester in round-robin order and registers the request into a single output stage.
- Enforces a global MSHR credit limit and a per-port in-flight limit.
- Provides a drain sequence (used before CQ reconfiguration and epoch changes) that stops grants and waits for all outstanding requests to retire.

Parameters:
- N_PORTS, 4, number of requesters (instantiated with swarm::L2_PORTS)
- ADDR_W, 34, request address width (swarm::ADDR_BITS)
- ID_W, 8, requester-local transaction id width
- LOG_N_MSHR, 4, log2 of global credit pool (2^LOG_N_MSHR outstanding)
- MAX_INFLIGHT, 4, per-port outstanding limit (1..2^LOG_N_MSHR)

Ports:
- clk, in, 1, clock
- rst, in, 1, synchronous active-high reset
- in_valid, in, N_PORTS, request valid per port
- in_ready, out, N_PORTS, request accepted per port (one-hot or zero)
- in_addr, in, N_PORTS*ADDR_W, per-port address, port i at [i*ADDR_W +: ADDR_W]
- in_id, in, N_PORTS*ID_W, per-port transaction id
- in_write, in, N_PORTS, per-port write flag
- out_valid, out, 1, registered request valid
- out_ready, in, 1, L2 pipeline accepts
- out_addr, out, ADDR_W, granted address
- out_id, out, ID_W, granted id
- out_write, out, 1, granted write flag
- out_port, out, $clog2(N_PORTS), granted port index
- resp_valid, in, 1, L2 retired one request (returns one credit)
- resp_port, in, $clog2(N_PORTS), port of the retired request
- drain_req, in, 1, level; request a drain
- drain_done, out, 1, drained and idle while drain_req held
- credit_err, out, 1, sticky; resp_valid seen for a port with zero in-flight

Behaviour:
- Reset:
  - out_valid=0, drain_done=0, credit_err=0, RR pointer=0.
  - Credits = 2^LOG_N_MSHR; all per-port counts = 0; FSM = RUN.
  - Reset mid-operation discards the held request and all in-flight accounting.
- Load condition: load = (!out_valid || out_ready) && credits>0 && FSM==RUN.
- Eligibility: port i is eligible iff in_valid[i] && cnt[i]<MAX_INFLIGHT.
- Grant:
  - When load is true, the first eligible port at or after the pointer (wrapping modulo N_PORTS) gets in_ready[i]=1 (combinational).
  - The pointer moves to (i+1) mod N_PORTS.
  - If no port is eligible, the pointer is unchanged.
- Latency:
  - A request accepted at cycle t appears on out_* at t+1.
  - out_* are held stable while out_valid && !out_ready.
  - A back-to-back grant is allowed in the same cycle out_ready pops the current request.
- Credits and counts:
  - On grant: credits-1 and cnt[i]+1.
  - On resp_valid: credits+1 and cnt[resp_port]-1.
  - Grant and response in the same cycle (including on the same port) net to zero change.
  - Credits never exceed 2^LOG_N_MSHR.
- credit_err:
  - resp_valid with cnt[resp_port]==0 sets credit_err.
  - The counter is not decremented and the credit is not returned.
  - credit_err is cleared only by rst.
- FSM:
  - RUN: drain_req=1 → DRAIN.
  - DRAIN: grants blocked. A held out_valid request still completes normally. When !out_valid && credits==2^LOG_N_MSHR → IDLE.
  - IDLE: drain_done=1. drain_req=0 → RUN, with drain_done falling in the same cycle as the transition.
  - drain_req deasserted while in DRAIN → RUN immediately.
- Input order: requests from the same port are issued in order. No reordering between ports beyond the round-robin policy.

Optional Feature:
- Macro: L2_ARB_STATS_EN.
- Defined:
  - Adds 32-bit per-port counters: grants, and conflict cycles (in_valid[i] high but not granted).
  - Adds a 32-bit count of credit-stall cycles (credits==0 with any in_valid).
  - Adds ports stat_sel (in, $clog2(N_PORTS)+1) and stat_rdata (out, 32). The registered read returns on the next cycle.
  - All counters zero on rst and saturate at all-ones.
- Undefined: no counters and no stat ports; all other behaviour is identical.

Decomposition:
- Package swarm gets:
  - typedef l2_arb_state_t (RUN, DRAIN, IDLE)
  - typedef l2_req_t {addr, id, write}
  - constant L2_ARB_MAX_INFLIGHT
- Sub-module rr_picker: combinational round-robin first-eligible search over N_PORTS with a pointer input. It returns the one-hot grant and the encoded index.

Test Plan:
- Ports 0..3 all valid, out_ready=1, resp_valid each cycle: grants 0,1,2,3,0 on consecutive cycles, out_port matches at t+1.
- No responses, port 0 only valid: exactly 4 grants (MAX_INFLIGHT), then in_ready[0]=0. One resp for port 0 → exactly one more grant.
- All 4 ports valid, no responses: exactly 16 grants, then all in_ready=0. One resp_valid → exactly one further grant.
- out_ready=0 while one request is held: out_addr/out_id stable for 10 cycles and no new in_ready. out_ready=1 → pop and new grant the same cycle.
- drain_req with 3 in-flight: no grants; drain_done rises the cycle after the 3rd resp_valid. drain_req=0 → grants resume the next cycle.
- resp_valid with resp_port=2 and cnt[2]=0: credit_err=1 and sticky, credits unchanged. rst clears it.
